// File: rtl/uart_pkg.sv
// Shared UART encodings: bit-position codes for uart_send_sta and the default bit time.
// Also used by the upstream byte sequencer, so the codes must not change.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 434;  // 50 MHz / 115200 baud

    localparam logic [3:0] ST_START = 4'd0;
    localparam logic [3:0] ST_D0    = 4'd1;
    localparam logic [3:0] ST_D7    = 4'd8;
    localparam logic [3:0] ST_STOP  = 4'd9;
    localparam logic [3:0] ST_IDLE  = 4'd15;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time counter: bit_end_o is high on count CLKS_PER_BIT-1, then the count wraps to 0.
// Restart is synchronous and has priority. There is no backpressure; the counter free-runs unless restarted.
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    output logic bit_end_o
);

    localparam int unsigned   CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign bit_end_o = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart_i || bit_end_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. A frame starts on the edge after a uart_send rising edge is seen while idle, and lasts 10*CLKS_PER_BIT cycles.
// Requests seen while busy are dropped, not queued; one idle cycle always separates frames.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_send,
    input  logic [7:0] send_data,
    output logic       txd,
    output logic       uart_send_done,
    output logic [3:0] uart_send_sta,
    output logic       busy
);

    logic       uart_send_q;
    logic       armed_q;
    logic [3:0] sta_q,   sta_d;
    logic [7:0] shreg_q, shreg_d;
    logic       txd_q,   txd_d;
    logic       busy_q,  busy_d;
    logic       req;
    logic       bit_end;

    // armed_q blocks a level that was already high when reset was released
    assign req = uart_send & ~uart_send_q & armed_q;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .rst_n     (rst),
        .restart_i (sta_q == ST_IDLE),
        .bit_end_o (bit_end)
    );

    always_comb begin
        sta_d   = sta_q;
        shreg_d = shreg_q;
        txd_d   = txd_q;
        busy_d  = busy_q;
        if (sta_q == ST_IDLE) begin
            if (req) begin
                sta_d   = ST_START;
                shreg_d = send_data;
                txd_d   = 1'b0;
                busy_d  = 1'b1;
            end
        end else if (sta_q > ST_STOP) begin
            sta_d  = ST_IDLE;
            txd_d  = 1'b1;
            busy_d = 1'b0;
        end else if (bit_end) begin
            if (sta_q == ST_STOP) begin
                sta_d  = ST_IDLE;
                txd_d  = 1'b1;
                busy_d = 1'b0;
            end else if (sta_q == ST_D7) begin
                sta_d = ST_STOP;
                txd_d = 1'b1;
            end else begin
                sta_d   = sta_q + 4'd1;
                txd_d   = shreg_q[0];
                shreg_d = {1'b0, shreg_q[7:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            uart_send_q <= 1'b0;
            armed_q     <= 1'b0;
            sta_q       <= ST_IDLE;
            shreg_q     <= '0;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            uart_send_q <= uart_send;
            armed_q     <= armed_q | ~uart_send;
            sta_q       <= sta_d;
            shreg_q     <= shreg_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
        end
    end

    assign txd            = txd_q;
    assign uart_send_done = (sta_q == ST_STOP) & bit_end;
    assign uart_send_sta  = sta_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Randomised bench for uart_tx: a line receiver decodes every frame and checks bit timing and status outputs.
module tb_uart_tx;

    localparam int CPB = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk;
    logic       rst;
    logic       uart_send;
    logic [7:0] send_data;
    logic       txd;
    logic       done;
    logic [3:0] sta;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk            (clk),
        .rst            (rst),
        .uart_send      (uart_send),
        .send_data      (send_data),
        .txd            (txd),
        .uart_send_done (done),
        .uart_send_sta  (sta),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line receiver: decodes frames from txd alone, using only the 8N1 timing rules
    int         cyc = 0;
    int         done_cnt = 0;
    int         busy_cyc = 0;
    logic       rx_act = 1'b0;
    logic       post = 1'b0;
    int         rx_k = 0;
    int         rx_start = 0;
    int         sta_err, busy_err, done_err, width_err;
    logic       samp [0:FRAME-1];
    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];
    int         start_q [$];

    always @(negedge clk) begin
        logic [7:0] b;
        cyc++;
        if (done === 1'b1) done_cnt++;
        if (sta !== 4'd15) busy_cyc++;
        if (!rst) begin
            rx_act = 1'b0;
            post   = 1'b0;
        end else begin
            if (post) begin
                check_eq("post_txd", 32'(txd), 1);
                check_eq("post_sta", 32'(sta), 15);
                check_eq("post_busy", 32'(busy), 0);
                check_eq("frame_len", 32'(cyc - rx_start), FRAME);
                post = 1'b0;
            end
            if (!rx_act && txd === 1'b0) begin
                rx_act = 1'b1;
                rx_k = 0;
                rx_start = cyc;
                sta_err = 0; busy_err = 0; done_err = 0; width_err = 0;
                start_q.push_back(cyc);
            end
            if (rx_act) begin
                samp[rx_k] = txd;
                if (sta !== 4'(rx_k / CPB)) sta_err++;
                if (busy !== 1'b1) busy_err++;
                if (done !== (rx_k == FRAME - 1)) done_err++;
                if ((rx_k % CPB) != 0 && txd !== samp[rx_k-1]) width_err++;
                if (rx_k == FRAME - 1) begin
                    for (int i = 0; i < 8; i++) b[i] = samp[CPB*(i+1) + CPB/2];
                    check_eq("stop_bit", 32'(samp[9*CPB]), 1);
                    check_eq("bit_width", 32'(width_err), 0);
                    check_eq("sta_seq", 32'(sta_err), 0);
                    check_eq("busy_in_frame", 32'(busy_err), 0);
                    check_eq("done_pos", 32'(done_err), 0);
                    rx_q.push_back(b);
                    rx_act = 1'b0;
                    post = 1'b1;
                end else begin
                    rx_k++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_send(input logic [7:0] b);
        uart_send = 1'b1;
        send_data = b;
        tick();
        uart_send = 1'b0;
    endtask

    task automatic wait_sta(input logic [3:0] s, input string tag);
        int n = 0;
        while (sta !== s && n < 100) begin tick(); n++; end
        check_eq(tag, 32'(n < 100), 1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 100) begin tick(); n++; end
        check_eq(tag, 32'(n < 100), 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin tick(); n++; end
        check_eq(tag, 32'(n < 100), 1);
    endtask

    task automatic compare_frames();
        int n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        check_eq("frame_count", 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < n; i++) check_eq("frame_data", 32'(rx_q[i]), 32'(exp_q[i]));
        rx_q.delete();
        exp_q.delete();
        start_q.delete();
    endtask

    initial begin
        int d0, bc0, gap;
        logic [7:0] b;

        rst = 1'b0;
        uart_send = 1'b0;
        send_data = 8'h00;
        repeat (3) tick();
        check_eq("rst_txd", 32'(txd), 1);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_sta", 32'(sta), 15);
        check_eq("rst_busy", 32'(busy), 0);
        rst = 1'b1;
        repeat (2) tick();

        // single frame 0xA5, with send_data scrambled after acceptance
        d0 = done_cnt;
        exp_q.push_back(8'hA5);
        pulse_send(8'hA5);
        check_eq("accept_txd", 32'(txd), 0);
        check_eq("accept_sta", 32'(sta), 0);
        check_eq("accept_busy", 32'(busy), 1);
        send_data = 8'h5A;
        wait_idle("idle_a5");
        repeat (2) tick();
        compare_frames();
        check_eq("done_once_a5", 32'(done_cnt - d0), 1);

        // held request produces exactly one frame
        d0 = done_cnt;
        bc0 = busy_cyc;
        exp_q.push_back(8'h3C);
        uart_send = 1'b1;
        send_data = 8'h3C;
        repeat (100) tick();
        uart_send = 1'b0;
        repeat (3) tick();
        compare_frames();
        check_eq("held_done", 32'(done_cnt - d0), 1);
        check_eq("held_busy_cycles", 32'(busy_cyc - bc0), FRAME);
        check_eq("held_sta_idle", 32'(sta), 15);

        // request while busy is dropped
        d0 = done_cnt;
        exp_q.push_back(8'h55);
        pulse_send(8'h55);
        wait_sta(4'd4, "wait_sta4");
        uart_send = 1'b1;
        send_data = 8'hFF;
        repeat (3) tick();
        uart_send = 1'b0;
        wait_idle("idle_55");
        repeat (FRAME + 5) tick();
        compare_frames();
        check_eq("collision_done", 32'(done_cnt - d0), 1);

        // asynchronous reset mid-frame, then held level after release
        d0 = done_cnt;
        pulse_send(8'h3F);
        wait_sta(4'd5, "wait_sta5");
        #2;
        rst = 1'b0;
        uart_send = 1'b1;
        #1;
        check_eq("arst_txd", 32'(txd), 1);
        check_eq("arst_sta", 32'(sta), 15);
        check_eq("arst_busy", 32'(busy), 0);
        check_eq("arst_done", 32'(done), 0);
        repeat (2) tick();
        rst = 1'b1;
        bc0 = busy_cyc;
        repeat (10) tick();
        check_eq("held_after_rst", 32'(busy_cyc - bc0), 0);
        uart_send = 1'b0;
        tick();
        exp_q.push_back(8'h81);
        pulse_send(8'h81);
        wait_idle("idle_81");
        repeat (2) tick();
        compare_frames();
        check_eq("arst_done_total", 32'(done_cnt - d0), 1);

        // back-to-back 0x01..0x05, re-raising after each done
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(8'(i));
            pulse_send(8'(i));
            wait_done("b2b_done");
            tick();
        end
        wait_idle("idle_b2b");
        repeat (2) tick();
        if (start_q.size() == 5) begin
            for (int i = 0; i < 4; i++) begin
                gap = start_q[i+1] - (start_q[i] + FRAME);
                check_eq("b2b_gap", 32'(gap >= 1), 1);
            end
            check_eq("b2b_total", 32'((start_q[4] + FRAME - start_q[0]) <= 5 * (FRAME + 3)), 1);
        end else begin
            check_eq("b2b_starts", 32'(start_q.size()), 5);
        end
        compare_frames();

        // random bytes, random gaps, noise on inputs during frames
        for (int i = 0; i < 8; i++) begin
            int n;
            b = 8'($urandom);
            repeat ($urandom_range(0, 4)) tick();
            exp_q.push_back(b);
            pulse_send(b);
            n = 0;
            while (done !== 1'b1 && n < 100) begin
                send_data = 8'($urandom);
                uart_send = (sta >= 4'd1 && sta <= 4'd6) ? 1'($urandom_range(0, 1)) : 1'b0;
                tick();
                n++;
            end
            check_eq("rand_done", 32'(n < 100), 1);
            uart_send = 1'b0;
            tick();
        end
        wait_idle("idle_rand");
        repeat (2) tick();
        compare_frames();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
